// File: rtl/sdrc_req_arb.sv
// sdrc_req_arb: round-robin (optional port-0 priority) arbiter sharing the sdrc_req_gen request port
module sdrc_req_arb #(
  parameter int NP         = 4,
  parameter int APP_AW     = 30,
  parameter int APP_RW     = 9,
  parameter int ID_W       = 4,
  parameter int HP_EN      = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NP-1:0]            p_req,
  input  logic [NP*ID_W-1:0]       p_req_id,
  input  logic [NP*(APP_AW+1)-1:0] p_req_addr,
  input  logic [NP*(APP_AW-1)-1:0] p_req_addr_mask,
  input  logic [NP*APP_RW-1:0]     p_req_len,
  input  logic [NP-1:0]            p_req_wr_n,
  input  logic [NP-1:0]            p_req_wrap,
  output logic [NP-1:0]            p_req_ack,
  output logic                     req,
  output logic [ID_W-1:0]          req_id,
  output logic [APP_AW:0]          req_addr,
  output logic [APP_AW-2:0]        req_addr_mask,
  output logic [APP_RW-1:0]        req_len,
  output logic                     req_wr_n,
  output logic                     req_wrap,
  input  logic                     req_ack,
  output logic [NP-1:0]            arb_gnt,
  output logic                     arb_busy
);
  localparam int AW = APP_AW + 1;
  localparam int MW = APP_AW - 1;
  localparam int PW = $clog2(NP);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [NP-1:0] cand;
  logic [PW-1:0] rr_ptr, win, gidx;
  logic [SW-1:0] starve_cnt;
  logic starved, found, hit, ack;
  int idx;
  assign hit = |(p_req & arb_gnt);
  assign ack = state == GRANT && hit && req_ack;
  assign arb_busy = state == GRANT;
  // winner: first pending port from rr_ptr, port 0 first when priority is on and not starving others
  always_comb begin
    starved = HP_EN != 0 && starve_cnt == SW'(STARVE_MAX) && |p_req[NP-1:1];
    cand = starved ? p_req & ~NP'(1) : p_req;
    win = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NP; k++) begin
      idx = (int'(rr_ptr) + k) % NP;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win = PW'(idx);
      end
    end
    if (HP_EN != 0 && p_req[0] && !starved) win = '0;
  end
  // index of the currently granted port
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NP; i++) if (arb_gnt[i]) gidx = PW'(i);
  end
  // next state: hold the grant until accepted or abandoned by the requester
  always_comb state_nxt = state == IDLE ? (|p_req ? GRANT : IDLE) : (hit && !req_ack ? GRANT : IDLE);
  // state, grant, round-robin pointer and starvation counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      arb_gnt <= '0;
      rr_ptr <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      arb_gnt <= state_nxt == GRANT ? (state == IDLE ? NP'(1) << win : arb_gnt) : '0;
      if (ack) begin
        rr_ptr <= PW'((int'(gidx) + 1) % NP);
        starve_cnt <= !arb_gnt[0] ? '0 :
                      (|p_req[NP-1:1] && starve_cnt != SW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
      end
    end
  end
  // request, accept pulse and field mux from the granted port
  always_comb begin
    req = state == GRANT && hit;
    p_req_ack = ack ? arb_gnt : '0;
    req_id = '0;
    req_addr = '0;
    req_addr_mask = '0;
    req_len = '0;
    req_wr_n = 1'b0;
    req_wrap = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (arb_gnt[i]) begin
        req_id = p_req_id[i*ID_W +: ID_W];
        req_addr = p_req_addr[i*AW +: AW];
        req_addr_mask = p_req_addr_mask[i*MW +: MW];
        req_len = p_req_len[i*APP_RW +: APP_RW];
        req_wr_n = p_req_wr_n[i];
        req_wrap = p_req_wrap[i];
      end
    end
  end
endmodule

// File: tb/tb_sdrc_req_arb.sv
// tb_sdrc_req_arb: vector table, directed corner cases and model-checked random traffic
module tb_sdrc_req_arb;
  localparam int NP = 4, AW = 31, MW = 29, RW = 9, IW = 4, SM = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [NP-1:0] p_req = '0, hp_p_req = '0, p_req_wr_n = '0, p_req_wrap = '0;
  logic [NP*IW-1:0] p_req_id = '0;
  logic [NP*AW-1:0] p_req_addr = '0;
  logic [NP*MW-1:0] p_req_addr_mask = '0;
  logic [NP*RW-1:0] p_req_len = '0;
  logic req_ack = 1'b0, hp_req_ack = 1'b0;
  logic [NP-1:0] p_req_ack, arb_gnt, hp_p_req_ack, hp_arb_gnt;
  logic req, req_wr_n, req_wrap, arb_busy, hp_req, hp_req_wr_n, hp_req_wrap, hp_arb_busy;
  logic [IW-1:0] req_id, hp_req_id;
  logic [AW-1:0] req_addr, hp_req_addr;
  logic [MW-1:0] req_addr_mask, hp_req_addr_mask;
  logic [RW-1:0] req_len, hp_req_len;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  sdrc_req_arb #(.NP(NP)) dut (
    .clk(clk), .reset_n(reset_n), .p_req(p_req), .p_req_id(p_req_id), .p_req_addr(p_req_addr),
    .p_req_addr_mask(p_req_addr_mask), .p_req_len(p_req_len), .p_req_wr_n(p_req_wr_n),
    .p_req_wrap(p_req_wrap), .p_req_ack(p_req_ack), .req(req), .req_id(req_id), .req_addr(req_addr),
    .req_addr_mask(req_addr_mask), .req_len(req_len), .req_wr_n(req_wr_n), .req_wrap(req_wrap),
    .req_ack(req_ack), .arb_gnt(arb_gnt), .arb_busy(arb_busy));
  sdrc_req_arb #(.NP(NP), .HP_EN(1), .STARVE_MAX(SM)) dut_hp (
    .clk(clk), .reset_n(reset_n), .p_req(hp_p_req), .p_req_id(p_req_id), .p_req_addr(p_req_addr),
    .p_req_addr_mask(p_req_addr_mask), .p_req_len(p_req_len), .p_req_wr_n(p_req_wr_n),
    .p_req_wrap(p_req_wrap), .p_req_ack(hp_p_req_ack), .req(hp_req), .req_id(hp_req_id),
    .req_addr(hp_req_addr), .req_addr_mask(hp_req_addr_mask), .req_len(hp_req_len),
    .req_wr_n(hp_req_wr_n), .req_wrap(hp_req_wrap), .req_ack(hp_req_ack), .arb_gnt(hp_arb_gnt),
    .arb_busy(hp_arb_busy));

  typedef struct { logic [NP-1:0] pr; logic ra; logic er; logic [NP-1:0] ea; logic [NP-1:0] eg; } vec_t;
  typedef struct { bit busy; int g; int rr; int starve; } mdl_t;
  vec_t tv[25];
  mdl_t m0, m1;
  int acks[$];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // arbitration rules: port 0 first under priority unless others starve, else rotate from rr
  function automatic int pick(mdl_t m, logic [NP-1:0] pr, bit hp);
    bit starved = hp && m.starve == SM && (pr[3] || pr[2] || pr[1]);
    if (hp && pr[0] && !starved) return 0;
    for (int k = 0; k < NP; k++) begin
      int i = (m.rr + k) % NP;
      if (pr[i] && !(starved && i == 0)) return i;
    end
    return -1;
  endfunction

  function automatic mdl_t step(mdl_t m, logic [NP-1:0] pr, logic ra, bit hp);
    bit others = pr[3] || pr[2] || pr[1];
    if (m.busy) begin
      if (pr[m.g] && ra) begin
        if (m.g != 0) m.starve = 0;
        else if (others && m.starve < SM) m.starve = m.starve + 1;
        m.rr = (m.g + 1) % NP;
        m.busy = 0;
      end else if (!pr[m.g]) m.busy = 0;
    end else if (pr != 0) begin
      m.g = pick(m, pr, hp);
      m.busy = 1;
    end
    return m;
  endfunction

  function automatic logic [127:0] port_fields(int g);
    return {p_req_id[g*IW +: IW], p_req_addr[g*AW +: AW], p_req_addr_mask[g*MW +: MW],
            p_req_len[g*RW +: RW], p_req_wr_n[g], p_req_wrap[g]};
  endfunction

  function automatic logic [NP-1:0] nxt_req(logic [NP-1:0] cur, logic [NP-1:0] acked);
    logic [NP-1:0] r;
    for (int i = 0; i < NP; i++)
      r[i] = acked[i] ? 1'($urandom % 2) : cur[i] ? 1'(($urandom % 16) != 0) : 1'(($urandom % 3) == 0);
    return r;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic check_model(string tag, mdl_t m, logic [NP-1:0] pr, logic ra, logic [NP-1:0] a_ack,
                             logic a_req, logic [NP-1:0] a_gnt, logic a_busy, logic [127:0] a_f);
    logic er = m.busy && pr[m.g];
    chk({tag, "_req"}, a_req, er);
    chk({tag, "_ack"}, a_ack, er && ra ? NP'(1) << m.g : '0);
    chk({tag, "_gnt"}, a_gnt, m.busy ? NP'(1) << m.g : '0);
    chk({tag, "_busy"}, a_busy, m.busy);
    chk({tag, "_fields"}, a_f, m.busy ? port_fields(m.g) : '0);
  endtask

  initial begin
    logic [NP-1:0] a0, a1;
    tv[0] = '{4'hF, 1, 0, 4'h0, 4'h0};   tv[1] = '{4'hF, 1, 1, 4'h1, 4'h1};
    tv[2] = '{4'hF, 1, 0, 4'h0, 4'h0};   tv[3] = '{4'hF, 1, 1, 4'h2, 4'h2};
    tv[4] = '{4'hF, 1, 0, 4'h0, 4'h0};   tv[5] = '{4'hF, 1, 1, 4'h4, 4'h4};
    tv[6] = '{4'hF, 1, 0, 4'h0, 4'h0};   tv[7] = '{4'hF, 1, 1, 4'h8, 4'h8};
    tv[8] = '{4'hF, 1, 0, 4'h0, 4'h0};   tv[9] = '{4'hF, 1, 1, 4'h1, 4'h1};
    tv[10] = '{4'h2, 0, 0, 4'h0, 4'h0};
    for (int i = 11; i <= 15; i++) tv[i] = '{4'h2, 0, 1, 4'h0, 4'h2};
    tv[16] = '{4'h2, 1, 1, 4'h2, 4'h2};  tv[17] = '{4'h0, 0, 0, 4'h0, 4'h0};
    tv[18] = '{4'h4, 0, 0, 4'h0, 4'h0};  tv[19] = '{4'h4, 0, 1, 4'h0, 4'h4};
    tv[20] = '{4'h0, 1, 0, 4'h0, 4'h4};  tv[21] = '{4'h0, 0, 0, 4'h0, 4'h0};
    tv[22] = '{4'h6, 1, 0, 4'h0, 4'h0};  tv[23] = '{4'h6, 1, 1, 4'h4, 4'h4};
    tv[24] = '{4'h0, 0, 0, 4'h0, 4'h0};
    #2;
    chk("reset_req", req, 1'b0);
    chk("reset_gnt", arb_gnt, '0);
    chk("reset_busy", arb_busy, 1'b0);
    chk("reset_fields", {req_id, req_addr, req_len}, '0);
    do_reset();
    for (int i = 0; i < 25; i++) begin
      p_req = tv[i].pr;
      req_ack = tv[i].ra;
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), req, tv[i].er);
      chk($sformatf("vec%0d_ack", i), p_req_ack, tv[i].ea);
      chk($sformatf("vec%0d_gnt", i), arb_gnt, tv[i].eg);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < NP; i++) begin
      p_req_id[i*IW +: IW] = IW'(i + 9);
      p_req_addr[i*AW +: AW] = AW'(32'h7000_0000 + i);
      p_req_addr_mask[i*MW +: MW] = MW'(i * 3 + 1);
      p_req_len[i*RW +: RW] = RW'(100 + i);
      p_req_wr_n[i] = 1'b1;
      p_req_wrap[i] = 1'b0;
    end
    p_req_id[3*IW +: IW] = 4'd5;
    p_req_addr[3*AW +: AW] = 31'h12345;
    p_req_len[3*RW +: RW] = 9'd8;
    p_req_wr_n[3] = 1'b0;
    p_req_wrap[3] = 1'b1;
    p_req = 4'h8;
    req_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mux_gnt", arb_gnt, 4'h8);
    chk("mux_fields", {req, req_id, req_addr, req_len, req_wr_n, req_wrap},
        {1'b1, 4'd5, 31'h12345, 9'd8, 1'b0, 1'b1});
    chk("mux_mask", req_addr_mask, 29'd10);
    req_ack = 1'b1;
    #1 chk("mux_ack", p_req_ack, 4'h8);
    @(posedge clk);
    #1 p_req = 4'h0;
    req_ack = 1'b0;
    @(posedge clk);
    #1 p_req = 4'h4;
    @(posedge clk);
    @(negedge clk);
    chk("rst_pre_gnt", arb_gnt, 4'h4);
    reset_n = 1'b0;
    #1;
    chk("rst_async_req", req, 1'b0);
    chk("rst_async_gnt", arb_gnt, 4'h0);
    chk("rst_async_busy", arb_busy, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_idle_ack", p_req_ack, 4'h0);
    req_ack = 1'b1;
    @(negedge clk);
    chk("rst_regrant_ack", p_req_ack, 4'h4);
    @(posedge clk);
    #1 p_req = 4'h0;
    req_ack = 1'b0;
    hp_p_req = 4'h9;
    hp_req_ack = 1'b1;
    for (int c = 0; c < 60 && acks.size() < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) if (hp_p_req_ack[i]) acks.push_back(i);
    end
    chk("hp_ack_count", acks.size(), 10);
    for (int i = 0; i < acks.size() && i < 10; i++) chk($sformatf("hp_ack%0d", i), acks[i], (i % 5 == 4) ? 3 : 0);
    @(posedge clk);
    #1 hp_p_req = 4'h0;
    hp_req_ack = 1'b0;
    do_reset();
    m0 = '{0, 0, 0, 0};
    m1 = '{0, 0, 0, 0};
    a0 = '0;
    a1 = '0;
    for (int c = 0; c < 3000; c++) begin
      p_req = nxt_req(p_req, a0);
      hp_p_req = nxt_req(hp_p_req, a1);
      req_ack = 1'(($urandom % 3) != 0);
      hp_req_ack = 1'(($urandom % 3) != 0);
      for (int i = 0; i < NP; i++) begin
        p_req_id[i*IW +: IW] = IW'($urandom);
        p_req_addr[i*AW +: AW] = AW'($urandom);
        p_req_addr_mask[i*MW +: MW] = MW'($urandom);
        p_req_len[i*RW +: RW] = RW'($urandom);
      end
      p_req_wr_n = NP'($urandom);
      p_req_wrap = NP'($urandom);
      @(negedge clk);
      check_model("rnd", m0, p_req, req_ack, p_req_ack, req, arb_gnt, arb_busy,
                  {req_id, req_addr, req_addr_mask, req_len, req_wr_n, req_wrap});
      check_model("rnd_hp", m1, hp_p_req, hp_req_ack, hp_p_req_ack, hp_req, hp_arb_gnt, hp_arb_busy,
                  {hp_req_id, hp_req_addr, hp_req_addr_mask, hp_req_len, hp_req_wr_n, hp_req_wrap});
      a0 = p_req_ack;
      a1 = hp_p_req_ack;
      m0 = step(m0, p_req, req_ack, 0);
      m1 = step(m1, hp_p_req, hp_req_ack, 1);
      @(posedge clk);
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
